// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core front end: branch conditions, next-PC sources, fetch states.
// The ERR fetch state exists only when IFU_ALIGN_CHECK_EN is defined.
package risc_pkg;

    typedef enum logic [3:0] {
        BR_NEVER  = 4'd0,
        BR_ALWAYS = 4'd1,
        BR_Z      = 4'd2,
        BR_NZ     = 4'd3,
        BR_S      = 4'd4,
        BR_GT     = 4'd5,
        BR_C      = 4'd6,
        BR_NC     = 4'd7,
        BR_V      = 4'd8,
        BR_NOV    = 4'd9
    } br_type_e;

    typedef enum logic [1:0] {
        CS_SEQ = 2'b00,
        CS_REL = 2'b01,
        CS_REG = 2'b10,
        CS_ABS = 2'b11
    } cs_e;

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_ERR} fetch_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_HOLD} fetch_state_e;
`endif

    localparam int INSTR_W = 32;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack port of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_branch_resolve.sv
// Combinational branch resolution: condition evaluation and next-PC selection.
module branch_resolve
    import risc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [3:0]        branch_type,
    input  logic [1:0]        counter_selector,
    input  logic              flag_z,
    input  logic              flag_s,
    input  logic              flag_c,
    input  logic              flag_v,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] rs_value,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc
);
    // Low 28 bits are replaced by an absolute target; upper bits come from pc + 4.
    localparam logic [ADDR_W-1:0] REGION_MASK = ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0]        pc_plus4;
    logic signed [ADDR_W-1:0] rel_offset;
    logic                     unused_opcode;

    assign pc_plus4      = pc + ADDR_W'(4);
    assign rel_offset    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign unused_opcode = ^instr[31:26];

    always_comb begin
        taken = 1'b0;
        case (branch_type)
            BR_NEVER:  taken = 1'b0;
            BR_ALWAYS: taken = 1'b1;
            BR_Z:      taken = flag_z;
            BR_NZ:     taken = !flag_z;
            BR_S:      taken = flag_s;
            BR_GT:     taken = !flag_s && !flag_z;
            BR_C:      taken = flag_c;
            BR_NC:     taken = !flag_c;
            BR_V:      taken = flag_v;
            BR_NOV:    taken = !flag_v;
            default:   taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        if (taken) begin
            case (cs_e'(counter_selector))
                CS_SEQ:  next_pc = pc_plus4;
                CS_REL:  next_pc = pc_plus4 + rel_offset;
                CS_REG:  next_pc = rs_value;
                CS_ABS:  next_pc = (pc_plus4 & ~REGION_MASK) | ADDR_W'({instr[25:0], 2'b00});
                default: next_pc = pc_plus4;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch / program-counter unit (IDLE -> FETCH -> HOLD loop).
// Define IFU_ALIGN_CHECK_EN to trap misaligned next-PC values in a sticky ERR state.
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic [INSTR_W-1:0]        instr,
    output logic [5:0]                opcode,
    output logic [5:0]                function_val,
    output logic                      instr_valid,
    output logic [ADDR_W-1:0]         pc,
    output logic [ADDR_W-1:0]         pc_link,
    input  logic                      exec_done,
    input  logic [3:0]                branch_type,
    input  logic [1:0]                counter_selector,
    input  logic                      flag_z,
    input  logic                      flag_s,
    input  logic                      flag_c,
    input  logic                      flag_v,
    input  logic [ADDR_W-1:0]         rs_value,
    output logic                      taken,
    output logic                      misalign_err
);
    fetch_state_e      state, state_next;
    logic              br_taken;
    logic [ADDR_W-1:0] next_pc_raw;
    logic [ADDR_W-1:0] next_pc_final;
    logic              fetch_accept;
    logic              exec_accept;
    logic              addr_fault;

    branch_resolve #(.ADDR_W(ADDR_W)) u_branch_resolve (
        .branch_type      (branch_type),
        .counter_selector (counter_selector),
        .flag_z           (flag_z),
        .flag_s           (flag_s),
        .flag_c           (flag_c),
        .flag_v           (flag_v),
        .pc               (pc),
        .instr            (instr),
        .rs_value         (rs_value),
        .taken            (br_taken),
        .next_pc          (next_pc_raw)
    );

    assign fetch_accept = (state == ST_FETCH) && imem.imem_ack;
    assign exec_accept  = (state == ST_HOLD) && exec_done;

`ifdef IFU_ALIGN_CHECK_EN
    assign next_pc_final = next_pc_raw;
    assign addr_fault    = (next_pc_raw[1:0] != 2'b00);
`else
    assign next_pc_final = next_pc_raw & ~ADDR_W'(3);
    assign addr_fault    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: if (imem.imem_ack) state_next = ST_HOLD;
`ifdef IFU_ALIGN_CHECK_EN
            ST_HOLD:  if (exec_done) state_next = addr_fault ? ST_ERR : ST_FETCH;
            ST_ERR:   state_next = ST_ERR;
`else
            ST_HOLD:  if (exec_done) state_next = ST_FETCH;
`endif
            default:  state_next = ST_IDLE;
        endcase
    end

    // A faulting target leaves pc on the instruction that produced it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= '0;
            taken <= 1'b0;
        end else begin
            if (fetch_accept) instr <= imem.imem_rdata;
            if (exec_accept) begin
                taken <= br_taken;
                if (!addr_fault) pc <= next_pc_final;
            end
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                        misalign_err <= 1'b0;
        else if (exec_accept && addr_fault) misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = pc;
    assign instr_valid    = (state == ST_HOLD);
    assign pc_link        = pc + ADDR_W'(4);
    assign opcode         = instr[31:26];
    assign function_val   = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed sequences, a vector table and a randomized run against a next-PC model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr, pc, pc_link, rs_value;
    logic [5:0]  opcode, function_val;
    logic        instr_valid, exec_done, taken, misalign_err;
    logic [3:0]  branch_type;
    logic [1:0]  counter_selector;
    logic        flag_z, flag_s, flag_c, flag_v;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_pc;

    instr_fetch_unit_if #(.ADDR_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus),
        .instr(instr), .opcode(opcode), .function_val(function_val),
        .instr_valid(instr_valid), .pc(pc), .pc_link(pc_link),
        .exec_done(exec_done), .branch_type(branch_type),
        .counter_selector(counter_selector),
        .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c), .flag_v(flag_v),
        .rs_value(rs_value), .taken(taken), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] iw;
        int          bt;
        int          cs;
        logic [3:0]  f;      // {z, s, c, v}
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference next-PC computed straight from the condition / source tables.
    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                             input int bt, input int cs, input logic [3:0] f,
                                             input logic [31:0] rs, output logic tk);
        logic z, s, c, v;
        longint target;
        z = f[3]; s = f[2]; c = f[1]; v = f[0];
        case (bt)
            1: tk = 1'b1;
            2: tk = z;
            3: tk = !z;
            4: tk = s;
            5: tk = !s && !z;
            6: tk = c;
            7: tk = !c;
            8: tk = v;
            9: tk = !v;
            default: tk = 1'b0;
        endcase
        target = longint'(cur_pc) + 4;
        if (tk) begin
            case (cs)
                1: target = longint'(cur_pc) + 4 + longint'($signed(iw[15:0])) * 4;
                2: target = longint'(rs);
                3: target = ((longint'(cur_pc) + 4) / (64'd1 << 28)) * (64'd1 << 28)
                            + longint'(iw[25:0]) * 4;
                default: target = longint'(cur_pc) + 4;
            endcase
        end
        target = target & 64'hFFFF_FFFF;
`ifndef IFU_ALIGN_CHECK_EN
        target = target & ~64'd3;
`endif
        return target[31:0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        exec_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        model_pc = 32'h0;
    endtask

    task automatic fetch(input logic [31:0] word, input int waits);
        int guard = 0;
        while (!bus.imem_req && guard < 8) begin
            tick();
            guard++;
        end
        check("fetch_req", {63'd0, bus.imem_req}, 64'd1);
        check("fetch_addr", {32'd0, bus.imem_addr}, {32'd0, model_pc});
        repeat (waits) begin
            tick();
            check("req_hold", {63'd0, bus.imem_req}, 64'd1);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        check("instr_valid", {63'd0, instr_valid}, 64'd1);
        check("req_drop", {63'd0, bus.imem_req}, 64'd0);
        check("instr", {32'd0, instr}, {32'd0, word});
    endtask

    task automatic exec(input int bt, input int cs, input logic [3:0] f, input logic [31:0] rs);
        branch_type = 4'(bt);
        counter_selector = 2'(cs);
        {flag_z, flag_s, flag_c, flag_v} = f;
        rs_value = rs;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        branch_type = 4'($urandom);
        rs_value = $urandom;
    endtask

    task automatic jump_to(input logic [31:0] addr);
        fetch(32'h0, 0);
        exec(1, 2, 4'b0000, addr);
        model_pc = addr;
        check("jump_pc", {32'd0, pc}, {32'd0, addr});
        check("jump_link", {32'd0, pc_link}, {32'd0, addr + 32'd4});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        tk;
        logic [31:0] exp_pc, iw, rs;
        logic [3:0]  f;
        int          bt, cs;

        vecs[0] = '{32'h100,       32'h0000_FFFE, 2,  1, 4'b1000, 32'h0,    32'hFC,        1'b1};
        vecs[1] = '{32'h100,       32'h0000_FFFE, 2,  1, 4'b0000, 32'h0,    32'h104,       1'b0};
        vecs[2] = '{32'h200,       32'h0,         1,  2, 4'b0000, 32'h2000, 32'h2000,      1'b1};
        vecs[3] = '{32'hFFFF_FFFC, 32'h0,         1,  0, 4'b0000, 32'h0,    32'h0,         1'b1};
        vecs[4] = '{32'h1000,      32'h0000_0010, 5,  1, 4'b0000, 32'h0,    32'h1044,      1'b1};
        vecs[5] = '{32'h1000,      32'h0000_0010, 5,  1, 4'b0100, 32'h0,    32'h1004,      1'b0};
        vecs[6] = '{32'h3000_0008, 32'h0000_0040, 1,  3, 4'b0000, 32'h0,    32'h3000_0100, 1'b1};
        vecs[7] = '{32'h400,       32'h0000_0001, 6,  1, 4'b0010, 32'h0,    32'h408,       1'b1};
        vecs[8] = '{32'h400,       32'h0,         12, 2, 4'b1111, 32'h5000, 32'h404,       1'b0};
        vecs[9] = '{32'h400,       32'h0,         9,  2, 4'b0000, 32'h6000, 32'h6000,      1'b1};

        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        exec_done = 1'b0;
        branch_type = 4'd0;
        counter_selector = 2'd0;
        {flag_z, flag_s, flag_c, flag_v} = 4'b0;
        rs_value = 32'h0;
        model_pc = 32'h0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_req", {63'd0, bus.imem_req}, 64'd0);
        check("rst_pc", {32'd0, pc}, 64'd0);
        check("rst_link", {32'd0, pc_link}, 64'd4);
        check("rst_instr", {32'd0, instr}, 64'd0);
        check("rst_opcode", {58'd0, opcode}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_taken", {63'd0, taken}, 64'd0);
        check("rst_misalign", {63'd0, misalign_err}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("first_req", {63'd0, bus.imem_req}, 64'd1);
        check("first_addr", {32'd0, bus.imem_addr}, 64'd0);

        // Ack on the first FETCH cycle, then sequential execute
        fetch(32'hA800_0015, 0);
        check("opcode", {58'd0, opcode}, 64'h2A);
        check("funct", {58'd0, function_val}, 64'h15);
        exec(0, 1, 4'b1111, 32'h0);
        model_pc = 32'h4;
        check("seq_pc", {32'd0, pc}, 64'h4);
        check("seq_taken", {63'd0, taken}, 64'd0);
        check("seq_valid_clr", {63'd0, instr_valid}, 64'd0);
        check("seq_req_up", {63'd0, bus.imem_req}, 64'd1);

        // exec_done during FETCH is ignored
        exec(1, 2, 4'b0000, 32'h8000);
        check("fetch_exec_pc", {32'd0, pc}, 64'h4);
        check("fetch_exec_req", {63'd0, bus.imem_req}, 64'd1);

        // Two wait cycles, then a stray ack while in HOLD
        fetch(32'h0000_0022, 2);
        check("funct_22", {58'd0, function_val}, 64'h22);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.imem_ack = 1'b0;
        check("hold_ack_instr", {32'd0, instr}, 64'h22);
        check("hold_ack_valid", {63'd0, instr_valid}, 64'd1);
        exec(0, 0, 4'b0000, 32'h0);
        model_pc = 32'h8;
        check("seq2_pc", {32'd0, pc}, 64'h8);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            jump_to(vecs[i].start_pc);
            fetch(vecs[i].iw, 0);
            exec(vecs[i].bt, vecs[i].cs, vecs[i].f, vecs[i].rs);
            model_pc = vecs[i].exp_pc;
            check($sformatf("vec%0d_pc", i), {32'd0, pc}, {32'd0, vecs[i].exp_pc});
            check($sformatf("vec%0d_taken", i), {63'd0, taken}, {63'd0, vecs[i].exp_taken});
        end

        // Randomized run against the model
        for (int i = 0; i < 150; i++) begin
            iw = $urandom;
            bt = int'($urandom_range(0, 15));
            cs = int'($urandom_range(0, 3));
            f  = 4'($urandom);
            rs = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
            rs = rs & ~32'd3;
`endif
            fetch(iw, int'($urandom_range(0, 2)));
            exp_pc = ref_next(model_pc, iw, bt, cs, f, rs, tk);
            exec(bt, cs, f, rs);
            check("rand_pc", {32'd0, pc}, {32'd0, exp_pc});
            check("rand_taken", {63'd0, taken}, {63'd0, tk});
            model_pc = exp_pc;
        end

        // Misaligned register target
        jump_to(32'h2000);
        fetch(32'h0, 0);
        exec(1, 2, 4'b0000, 32'h2002);
`ifdef IFU_ALIGN_CHECK_EN
        check("mis_err", {63'd0, misalign_err}, 64'd1);
        check("mis_req", {63'd0, bus.imem_req}, 64'd0);
        check("mis_valid", {63'd0, instr_valid}, 64'd0);
        check("mis_pc", {32'd0, pc}, 64'h2000);
        tick();
        exec(1, 2, 4'b0000, 32'h3000);
        tick();
        check("err_sticky", {63'd0, misalign_err}, 64'd1);
        check("err_req", {63'd0, bus.imem_req}, 64'd0);
        check("err_pc", {32'd0, pc}, 64'h2000);
`else
        check("mis_pc", {32'd0, pc}, 64'h2000);
        check("mis_err", {63'd0, misalign_err}, 64'd0);
        check("mis_req", {63'd0, bus.imem_req}, 64'd1);
`endif

        // Reset asserted mid-FETCH with an ack pending
        do_reset();
        check("rerun_req", {63'd0, bus.imem_req}, 64'd1);
        jump_to(32'h700);
        rst_n = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        tick();
        check("midrst_req", {63'd0, bus.imem_req}, 64'd0);
        check("midrst_pc", {32'd0, pc}, 64'h0);
        check("midrst_instr", {32'd0, instr}, 64'h0);
        check("midrst_valid", {63'd0, instr_valid}, 64'd0);
        check("midrst_misalign", {63'd0, misalign_err}, 64'd0);
        rst_n = 1'b1;
        bus.imem_ack = 1'b0;
        tick();
        check("postrst_req", {63'd0, bus.imem_req}, 64'd1);
        check("postrst_instr", {32'd0, instr}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch and program-counter unit for the single-issue RISC core. Holds the PC, fetches one 32-bit instruction per iteration over a req/ack instruction-memory port, and presents `opcode` and `function_val` to the control unit. On completion of execute it computes the next PC from the control unit's `branch_type` and `counter_selector` outputs and the ALU flags.

## Interface
- `ADDR_W`, 32: PC and memory address width (≥ 28).
- `RESET_PC`, 32'h0000_0000: PC loaded on reset. Must be word aligned.

- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address. Equals `pc`.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr` out 32: latched instruction.
- `opcode` out 6: `instr[31:26]`.
- `function_val` out 6: `instr[5:0]`.
- `instr_valid` out 1: `instr` is valid for decode and execute.
- `pc` out ADDR_W: address of the current instruction.
- `pc_link` out ADDR_W: `pc + 4`, the link value for call instructions.
- `exec_done` in 1: execute finished; next-PC inputs are valid this cycle.
- `branch_type` in 4: branch condition from the control unit.
- `counter_selector` in 2: next-PC source from the control unit.
- `flag_z`, `flag_s`, `flag_c`, `flag_v` in 1 each: ALU zero, sign, carry, overflow.
- `rs_value` in ADDR_W: register target for jump-register.
- `taken` out 1: the last resolved branch was taken.
- `misalign_err` out 1: sticky misaligned-target error.

## Operation
- States:
  - IDLE: entered from reset.
  - FETCH: `imem_req` = 1.
  - HOLD: `instr_valid` = 1, waiting for `exec_done`.
  - ERR: only when the alignment check is compiled in.
- Transitions:
  - IDLE → FETCH unconditionally.
  - FETCH → HOLD on `imem_ack`, latching `imem_rdata` into `instr`.
  - HOLD → FETCH on `exec_done`, loading the next PC.
  - HOLD → ERR on `exec_done` when the computed next PC has `[1:0]` ≠ 0 and the alignment check is compiled in.
- `branch_type` conditions:
  - 0: never taken.
  - 1: always taken.
  - 2: Z.
  - 3: !Z.
  - 4: S.
  - 5: !S && !Z.
  - 6: C.
  - 7: !C.
  - 8: V.
  - 9: !V.
  - 10–15: reserved, treated as not taken.
- `counter_selector` next-PC source when taken:
  - 00: `pc + 4`.
  - 01: PC-relative, `pc + 4 + (sext(instr[15:0]) << 2)`.
  - 10: `rs_value`.
  - 11: absolute, `{pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00}`.
- Not taken: next PC = `pc + 4`, regardless of `counter_selector`.
- Arithmetic: all adds are modulo 2^ADDR_W. The PC wraps from max to 0 with no error.
- `taken` updates only on an accepted `exec_done`.

## Timing
- Reset values:
  - State IDLE; `pc` = RESET_PC.
  - `instr`, `opcode`, `function_val` = 0.
  - `instr_valid`, `imem_req`, `taken`, `misalign_err` = 0.
  - `pc_link` = RESET_PC + 4.
- First `imem_req` is asserted one cycle after `rst_n` is released.
- `imem_req` stays high through FETCH until `imem_ack`.
- `imem_req` drops on the edge that samples `imem_ack`.
- `instr_valid` rises on that same edge.
- `imem_ack` while not in FETCH is ignored.
- `exec_done` is accepted only in HOLD. It is ignored in IDLE, FETCH and ERR.
- Flags, `branch_type`, `counter_selector` and `rs_value` are sampled in the same cycle as `exec_done`.
- On `exec_done`, the same edge:
  - loads `pc`;
  - clears `instr_valid`;
  - raises `imem_req`.
- Minimum loop is 2 cycles per instruction: ack in the first FETCH cycle, `exec_done` in the first HOLD cycle.
- Reset mid-fetch or mid-hold: abandon immediately. `imem_req` is low after the reset edge and the pending ack is discarded.
- ERR is exited only by reset. In ERR, `imem_req` = 0 and `instr_valid` = 0.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - A misaligned next PC enters ERR.
  - `misalign_err` = 1 from the transition edge until reset.
  - `pc` keeps the faulting instruction's address.
- `IFU_ALIGN_CHECK_EN` undefined:
  - No ERR state.
  - Next PC `[1:0]` is forced to 00.
  - `misalign_err` is tied to 0.

## Structure
- Shared package `risc_pkg` holds:
  - `branch_type` codes `BR_NEVER` … `BR_NOV`;
  - `counter_selector` codes `CS_SEQ`, `CS_REL`, `CS_REG`, `CS_ABS`;
  - the fetch-state enum.
- One combinational sub-module, `branch_resolve`:
  - inputs: condition, flags, `counter_selector`, `pc`, `instr`, `rs_value`;
  - outputs: `taken`, `next_pc`.
- The FSM and registers live in the top level.

## Test plan
- Reset then run, ack on the first FETCH cycle: `imem_addr` = 0 with `imem_req` = 1 one cycle after release; `instr_valid` = 1 the next cycle; `opcode`/`function_val` match the ack word.
- Two cycles of wait then ack with 32'h0000_0022; `exec_done` with `branch_type` = 0: `function_val` = 6'b100010; `pc` goes 0 → 4.
- `pc` = 32'h100, `instr[15:0]` = 16'hFFFE, `branch_type` = 2, `flag_z` = 1, `counter_selector` = 01: `pc` = 32'hFC, `taken` = 1. Repeat with `flag_z` = 0: `pc` = 32'h104, `taken` = 0.
- `counter_selector` = 10, `rs_value` = 32'h2000, `branch_type` = 1: `pc` = 32'h2000. With `rs_value` = 32'h2002: if `IFU_ALIGN_CHECK_EN`, `misalign_err` = 1 and `imem_req` stays 0; else `pc` = 32'h2000.
- `pc` = 32'hFFFF_FFFC, sequential: `pc` wraps to 0. `exec_done` pulsed in FETCH is ignored. Reset asserted mid-FETCH: `pc` = RESET_PC and `imem_req` = 0 after the edge.
